countdown_timer_bcd: RTL and testbench
======================================

Name: countdown_timer_bcd

Overview:
- Countdown timer from a loaded value (max 99.99 s) down to 00.00 s, at 1/100 s resolution.
- It is the counterpart of the stopwatch: it counts down instead of up, is preset from switches and buttons, and raises an expiry flag at zero.
- It uses the same 2-digit BCD on the 2 x 4-LED display, with SW selecting between seconds and hundredths.
- The whole block is clocked from CLK_50M using an internal 100 Hz tick enable. No derived clocks and no ripple carries.

Parameters:
- TICK_DIV, 500000, number of CLK_50M cycles per 1/100 s tick (minimum 2; benches use 4).

Ports:
- CLK_50M  in  1  system clock, 50 MHz.
- RST_N  in  1  asynchronous, active-low reset.
- load_value  in  16  BCD preset {deca[15:12], unit[11:8], deci[7:4], centi[3:0]}.
- load  in  1  single-cycle pulse: copy load_value into the counter.
- start_stop  in  1  single-cycle pulse: start, pause or resume.
- SW  in  1  display select. 1 shows {deca, unit}; 0 shows {deci, centi}.
- LED  out  8  registered display digits, BCD.
- running  out  1  high while in state RUN.
- expired  out  1  high while in state DONE.

Behaviour:
- Reset (RST_N low, asynchronous):
  - All four digits = 0, state = IDLE, prescaler = 0.
  - LED = 8'h00, running = 0, expired = 0.
- States: IDLE, RUN, PAUSE, DONE.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and is held at 0 in every other state.
  - tick is asserted for one cycle when the count is TICK_DIV-1.
  - The first tick after entering RUN occurs exactly TICK_DIV cycles after the start_stop cycle.
- Decrement, on each tick in RUN:
  - centi-1, borrowing into deci, unit, then deca.
  - A digit at 0 that receives a borrow becomes 9.
  - If the decremented value is 0000, enter DONE on the same edge. No wrap to 99.99 is allowed.
- Load:
  - Accepted in IDLE, PAUSE and DONE. The next state is IDLE.
  - Any BCD nibble >9 is clamped to 9 before it is stored.
  - Load is ignored in RUN.
- start_stop transitions:
  - IDLE with count != 0000 -> RUN.
  - IDLE with count == 0000 -> stays IDLE.
  - RUN -> PAUSE, digits frozen.
  - PAUSE -> RUN, prescaler restarts from 0.
  - DONE -> ignored.
- Simultaneous load and start_stop in the same cycle: load wins and start_stop is dropped.
- A tick coinciding with a start_stop pause: the decrement happens and the state goes to PAUSE on the same edge.
- DONE:
  - Digits stay 0000 and expired stays high.
  - Exit only via load (to IDLE) or reset.
- LED:
  - Registered mux, 1-cycle latency from any digit change or SW change.
  - SW=1 -> {deca, unit}; SW=0 -> {deci, centi}.
- running and expired are registered state decodes, valid the cycle after the transition edge.
- Reset asserted mid-RUN clears everything immediately. After release the block is in IDLE with a zero count.

Decomposition:
- Shared package timer_pkg:
  - State enum (IDLE, RUN, PAUSE, DONE).
  - BCD_W = 4, BCD_MAX = 4'd9.
  - Default TICK_DIV_100HZ = 500000.
- One sub-module, bcd_digit_down:
  - Inputs: clock, RST_N, load, load_digit (clamped), borrow_in.
  - Outputs: digit, borrow_out (= borrow_in && digit==0).
  - Instantiated four times.
- Prescaler, FSM and output mux stay in the top level.

Test Plan (TICK_DIV=4):
- Reset and idle:
  - Stimulus: reset, then start_stop with count 0000.
  - Required: LED=00, state stays IDLE, running=0, expired=0.
- Load with clamping:
  - Stimulus: load_value=16'h1A05, then load, SW=1.
  - Required: LED=8'h19 one cycle later; SW=0 -> LED=8'h05.
- Borrow chain and pause:
  - Stimulus: load 00.10, start_stop.
  - Required: after 4 cycles digits read 00.09, decrement is via borrow from deci.
  - Stimulus: pause, wait 20 cycles.
  - Required: digits unchanged; resume restarts the 4-cycle spacing.
- Expiry:
  - Stimulus: load 00.02, run.
  - Required: after 8 cycles digits = 00.00, expired=1, running=0.
  - Stimulus: further ticks and start_stop.
  - Required: no change and no wrap to 99.99.
  - Stimulus: load 01.00.
  - Required: expired=0, state IDLE.
- Priority and ignore rules:
  - Stimulus: load and start_stop in the same cycle from IDLE.
  - Required: value loaded, stays IDLE.
  - Stimulus: load during RUN.
  - Required: ignored, countdown continues.
- Mid-run reset:
  - Stimulus: assert RST_N low between clock edges while running 99.99.
  - Required: LED=00 immediately, no clock needed; running=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int              BCD_W          = 4;
  localparam logic [BCD_W-1:0] BCD_MAX        = 4'd9;
  localparam int              TICK_DIV_100HZ = 500000;

  // Out-of-range preset nibbles saturate to 9 rather than storing non-BCD codes.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD decade of the down counter: parallel load or borrow-driven decrement.
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic             clock,
  input  logic             RST_N,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_digit;
    end else if (borrow_in) begin
      digit_d = (digit_q == '0) ? BCD_MAX : (digit_q - 4'd1);
    end
  end

  always_ff @(posedge clock or negedge RST_N) begin
    if (!RST_N) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = borrow_in && (digit_q == '0);

endmodule

// File: rtl/countdown_timer_bcd.sv
// 00.00-99.99 s BCD countdown timer with 100 Hz tick, pause/resume and expiry flag.
module countdown_timer_bcd
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_100HZ
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic [15:0] load_value,
  input  logic        load,
  input  logic        start_stop,
  input  logic        SW,
  output logic [7:0]  LED,
  output logic        running,
  output logic        expired
);

  localparam int                PRESC_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         led_q, led_d;
  logic               running_q, running_d;
  logic               expired_q, expired_d;

  logic               tick;
  logic               load_ok;
  logic               count_zero;
  logic               count_one;
  logic [4:0]         borrow;
  logic               unused_borrow;
  logic [BCD_W-1:0]   digit [4];

  assign load_ok   = load && (state_q != RUN);
  assign tick      = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign borrow[0] = tick;
  assign unused_borrow = borrow[4];

  // digit[0]=centi, digit[1]=deci, digit[2]=unit, digit[3]=deca
  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit_down u_digit (
      .clock      (CLK_50M),
      .RST_N      (RST_N),
      .load       (load_ok),
      .load_digit (bcd_clamp(load_value[i*BCD_W +: BCD_W])),
      .borrow_in  (borrow[i]),
      .digit      (digit[i]),
      .borrow_out (borrow[i+1])
    );
  end

  assign count_zero = (digit[3] == '0) && (digit[2] == '0) && (digit[1] == '0) && (digit[0] == '0);
  assign count_one  = (digit[3] == '0) && (digit[2] == '0) && (digit[1] == '0) && (digit[0] == 4'd1);

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Load beats start_stop; reaching zero on a tick beats a coincident pause.
  always_comb begin
    state_d = state_q;
    if (load_ok) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_stop && !count_zero) state_d = RUN;
        RUN: begin
          if (tick && count_one)  state_d = DONE;
          else if (start_stop)    state_d = PAUSE;
        end
        PAUSE:   if (start_stop) state_d = RUN;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    presc_d   = '0;
    if ((state_q == RUN) && (state_d == RUN) && !tick) begin
      presc_d = presc_q + 1'b1;
    end
    led_d     = SW ? {digit[3], digit[2]} : {digit[1], digit[0]};
    running_d = (state_d == RUN);
    expired_d = (state_d == DONE);
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      presc_q   <= '0;
      led_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      led_q     <= led_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign LED     = led_q;
  assign running = running_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed plus random checks of countdown_timer_bcd against a centisecond-integer model.
module tb_countdown_timer_bcd;

  localparam int TICK_DIV = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic        CLK_50M = 1'b0;
  logic        RST_N;
  logic [15:0] load_value;
  logic        load;
  logic        start_stop;
  logic        SW;
  logic [7:0]  LED;
  logic        running;
  logic        expired;

  int nChecks = 0;
  int nPass   = 0;

  int         mValue;
  int         mMode;
  int         mPhase;
  logic [7:0] mLed;
  logic       mRun;
  logic       mExp;

  countdown_timer_bcd #(.TICK_DIV(TICK_DIV)) dut (
    .CLK_50M    (CLK_50M),
    .RST_N      (RST_N),
    .load_value (load_value),
    .load       (load),
    .start_stop (start_stop),
    .SW         (SW),
    .LED        (LED),
    .running    (running),
    .expired    (expired)
  );

  always #5 CLK_50M = ~CLK_50M;

  function automatic int clampVal(input logic [15:0] lv);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      int n = (int'(lv) >> (4 * i)) & 15;
      if (n > 9) n = 9;
      r = r * 10 + n;
    end
    return r;
  endfunction

  function automatic logic [7:0] ledOf(input int v, input logic sw);
    int hi, lo;
    if (sw) begin
      hi = v / 1000;
      lo = (v / 100) % 10;
    end else begin
      hi = (v / 10) % 10;
      lo = v % 10;
    end
    return 8'(hi * 16 + lo);
  endfunction

  task automatic modelReset();
    mValue = 0; mMode = M_IDLE; mPhase = 0;
    mLed = 8'h00; mRun = 1'b0; mExp = 1'b0;
  endtask

  // Model works on the value as a plain number of hundredths.
  task automatic modelStep(input bit ld, input bit ss, input logic sw, input logic [15:0] lv);
    logic [7:0] ledNext;
    ledNext = ledOf(mValue, sw);
    if (ld && mMode != M_RUN) begin
      mValue = clampVal(lv);
      mMode  = M_IDLE;
    end else if (mMode == M_RUN) begin
      mPhase++;
      if (mPhase == TICK_DIV) begin
        mPhase = 0;
        mValue--;
      end
      if (mValue == 0) mMode = M_DONE;
      else if (ss)     mMode = M_PAUSE;
    end else if (ss) begin
      if ((mMode == M_IDLE && mValue != 0) || mMode == M_PAUSE) begin
        mMode  = M_RUN;
        mPhase = 0;
      end
    end
    mLed = ledNext;
    mRun = (mMode == M_RUN);
    mExp = (mMode == M_DONE);
  endtask

  task automatic checkByte(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nChecks++;
    assert (got === exp) nPass++;
    else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      $error("[TB] %s", tag);
    end
  endtask

  task automatic checkBit(input string tag, input logic got, input logic exp);
    nChecks++;
    assert (got === exp) nPass++;
    else begin
      $display("[TB] FAIL %s: got %b, expected %b", tag, got, exp);
      $error("[TB] %s", tag);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkByte({tag, ".LED"}, LED, mLed);
    checkBit({tag, ".running"}, running, mRun);
    checkBit({tag, ".expired"}, expired, mExp);
  endtask

  task automatic applyStimulus(input string tag, input bit ld, input bit ss, input logic sw,
                               input logic [15:0] lv);
    @(negedge CLK_50M);
    load = ld; start_stop = ss; SW = sw; load_value = lv;
    @(posedge CLK_50M);
    modelStep(ld, ss, sw, lv);
    #1;
    load = 1'b0; start_stop = 1'b0;
    checkOutput(tag);
  endtask

  task automatic runCycles(input string tag, input int n, input logic sw);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, sw, 16'h0000);
  endtask

  initial begin
    RST_N = 1'b0; load = 1'b0; start_stop = 1'b0; SW = 1'b0; load_value = 16'h0000;
    modelReset();
    #12;
    checkByte("reset.LED", LED, 8'h00);
    checkBit("reset.running", running, 1'b0);
    checkBit("reset.expired", expired, 1'b0);
    @(negedge CLK_50M);
    RST_N = 1'b1;

    applyStimulus("idle_start_zero", 1'b0, 1'b1, 1'b0, 16'h0000);
    runCycles("idle_hold", 3, 1'b0);
    checkBit("idle_zero.running", running, 1'b0);

    applyStimulus("load_clamp", 1'b1, 1'b0, 1'b1, 16'h1A05);
    applyStimulus("load_clamp_hi", 1'b0, 1'b0, 1'b1, 16'h0000);
    checkByte("clamp_hi.LED", LED, 8'h19);
    applyStimulus("load_clamp_lo", 1'b0, 1'b0, 1'b0, 16'h0000);
    checkByte("clamp_lo.LED", LED, 8'h05);

    applyStimulus("load_0010", 1'b1, 1'b0, 1'b0, 16'h0010);
    applyStimulus("start_0010", 1'b0, 1'b1, 1'b0, 16'h0000);
    runCycles("borrow_run", 5, 1'b0);
    checkByte("borrow.LED", LED, 8'h09);
    applyStimulus("pause", 1'b0, 1'b1, 1'b0, 16'h0000);
    runCycles("paused", 20, 1'b0);
    checkByte("paused.LED", LED, 8'h09);
    checkBit("paused.running", running, 1'b0);
    applyStimulus("resume", 1'b0, 1'b1, 1'b0, 16'h0000);
    runCycles("resumed", 4, 1'b0);
    checkByte("resume_spacing.LED", LED, 8'h09);
    runCycles("resumed_tick", 1, 1'b0);
    checkByte("resume_tick.LED", LED, 8'h08);
    applyStimulus("pause2", 1'b0, 1'b1, 1'b0, 16'h0000);

    applyStimulus("load_0002", 1'b1, 1'b0, 1'b0, 16'h0002);
    applyStimulus("start_0002", 1'b0, 1'b1, 1'b0, 16'h0000);
    runCycles("expiry_run", 8, 1'b0);
    checkBit("expiry.expired", expired, 1'b1);
    checkBit("expiry.running", running, 1'b0);
    runCycles("done_hold", 10, 1'b1);
    applyStimulus("done_ss", 1'b0, 1'b1, 1'b0, 16'h0000);
    runCycles("done_after_ss", 6, 1'b0);
    checkByte("no_wrap.LED", LED, 8'h00);
    checkBit("no_wrap.expired", expired, 1'b1);
    applyStimulus("load_0100", 1'b1, 1'b0, 1'b1, 16'h0100);
    checkBit("reload.expired", expired, 1'b0);
    checkBit("reload.running", running, 1'b0);

    applyStimulus("load_and_ss", 1'b1, 1'b1, 1'b1, 16'h0305);
    runCycles("load_wins", 2, 1'b1);
    checkByte("load_wins.LED", LED, 8'h03);
    checkBit("load_wins.running", running, 1'b0);
    applyStimulus("start_0305", 1'b0, 1'b1, 1'b0, 16'h0000);
    runCycles("run_0305", 2, 1'b0);
    applyStimulus("load_in_run", 1'b1, 1'b0, 1'b0, 16'h0001);
    checkBit("load_in_run.running", running, 1'b1);
    runCycles("run_after_load", 12, 1'b0);
    applyStimulus("pause3", 1'b0, 1'b1, 1'b0, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      bit         ld, ss;
      logic       sw;
      logic [15:0] lv;
      ld = ($urandom_range(0, 19) == 0);
      ss = ($urandom_range(0, 5) == 0);
      sw = 1'($urandom_range(0, 1));
      lv = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 12));
      applyStimulus("random", ld, ss, sw, lv);
    end

    applyStimulus("load_9999", 1'b1, 1'b0, 1'b1, 16'h9999);
    applyStimulus("start_9999", 1'b0, 1'b1, 1'b1, 16'h0000);
    runCycles("run_9999", 6, 1'b1);
    checkByte("run_9999.LED", LED, 8'h99);
    #2;
    RST_N = 1'b0;
    #1;
    checkByte("async_reset.LED", LED, 8'h00);
    checkBit("async_reset.running", running, 1'b0);
    checkBit("async_reset.expired", expired, 1'b0);
    modelReset();
    @(negedge CLK_50M);
    RST_N = 1'b1;
    applyStimulus("post_reset_ss", 1'b0, 1'b1, 1'b1, 16'h0000);
    runCycles("post_reset_idle", 5, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
